// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register and its control decoders.
// The MODE encodings live here so every consumer agrees on the same 3-bit codes.
package univ_shift_reg_pkg;

  typedef logic [2:0] mode_t;

  localparam mode_t MODE_HOLD = 3'b000;
  localparam mode_t MODE_SHL  = 3'b001;
  localparam mode_t MODE_SHR  = 3'b010;
  localparam mode_t MODE_LOAD = 3'b011;
  localparam mode_t MODE_ROL  = 3'b100;
  localparam mode_t MODE_ROR  = 3'b101;
  localparam mode_t MODE_CLR  = 3'b110;
  localparam mode_t MODE_SET  = 3'b111;

endpackage

// File: rtl/shift_reg_cell.sv
// One bit of the universal register: an async-reset flop to a per-bit reset
// value, fed by an 8:1 next-state mux over hold, lower neighbour, upper
// neighbour, parallel data, constant 0 and constant 1.
module shift_reg_cell
  import univ_shift_reg_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  en_i,
  input  mode_t mode_i,
  input  logic  lo_i,   // bit below this one (or SIL / wrap bit at bit 0)
  input  logic  hi_i,   // bit above this one (or SIR / wrap bit at the MSB)
  input  logic  d_i,
  output logic  q_o
);

  logic q_q;
  logic q_d;

  // Next-state select: EN low holds regardless of MODE; unknown MODE yields X.
  always_comb begin
    q_d = q_q;
    if (en_i) begin
      case (mode_i)
        MODE_HOLD: q_d = q_q;
        MODE_SHL:  q_d = lo_i;
        MODE_SHR:  q_d = hi_i;
        MODE_LOAD: q_d = d_i;
        MODE_ROL:  q_d = lo_i;
        MODE_ROR:  q_d = hi_i;
        MODE_CLR:  q_d = 1'b0;
        MODE_SET:  q_d = 1'b1;
        default:   q_d = 1'bx;
      endcase
    end
  end

  // State flop: reset forces the per-bit reset value without needing a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= RESET_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: load, clear, preset, shift and rotate on one
// clock, with an asynchronous active-high reset to RESET_VAL. Built from one
// shift_reg_cell per bit; only the two end bits need mode-dependent inputs
// (serial-in for shifts, the opposite end bit for rotates).
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  mode_t            MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SOL,
  output logic             SOR,
  output logic             ZERO
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] lo_nbr;
  logic [WIDTH-1:0] hi_nbr;
  logic             lsb_in;
  logic             msb_in;

  // End-bit feed: rotates wrap the opposite end bit, shifts take serial input.
  always_comb begin
    lsb_in = SIL;
    msb_in = SIR;
    if (MODE == MODE_ROL) begin
      lsb_in = q_q[WIDTH-1];
    end
    if (MODE == MODE_ROR) begin
      msb_in = q_q[0];
    end
  end

  // Each bit sees its lower neighbour (left moves) and upper neighbour (right moves).
  assign lo_nbr = {q_q[WIDTH-2:0], lsb_in};
  assign hi_nbr = {msb_in, q_q[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    shift_reg_cell #(
      .RESET_BIT (RESET_VAL[i])
    ) u_cell (
      .clk_i  (CLK),
      .rst_i  (RST),
      .en_i   (EN),
      .mode_i (MODE),
      .lo_i   (lo_nbr[i]),
      .hi_i   (hi_nbr[i]),
      .d_i    (D[i]),
      .q_o    (q_q[i])
    );
  end

  // Outputs derive only from the registered bits, so they cannot glitch on input changes.
  assign Q    = q_q;
  assign QN   = ~q_q;
  assign SOL  = q_q[WIDTH-1];
  assign SOR  = q_q[0];
  assign ZERO = (q_q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed sequences on an 8-bit instance with reset
// value 8'hA5, plus random traffic on 2-bit and 32-bit instances reset to 0.
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;

  logic CLK = 1'b0;
  logic clk_run = 1'b0;

  always begin
    #5;
    if (clk_run) CLK = ~CLK;
  end

  // 8-bit directed instance
  logic       rst8 = 1'b0, en8 = 1'b0, sil8 = 1'b0, sir8 = 1'b0;
  mode_t      mode8 = MODE_HOLD;
  logic [7:0] d8 = '0;
  logic [7:0] q8, qn8;
  logic       sol8, sor8, zero8;

  // random instances
  logic        rstr = 1'b0;
  logic        en2 = 1'b0, sil2 = 1'b0, sir2 = 1'b0;
  mode_t       mode2 = MODE_HOLD;
  logic [1:0]  d2 = '0;
  logic [1:0]  q2, qn2;
  logic        sol2, sor2, zero2;
  logic        en32 = 1'b0, sil32 = 1'b0, sir32 = 1'b0;
  mode_t       mode32 = MODE_HOLD;
  logic [31:0] d32 = '0;
  logic [31:0] q32, qn32;
  logic        sol32, sor32, zero32;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .CLK(CLK), .RST(rst8), .EN(en8), .MODE(mode8), .D(d8), .SIL(sil8), .SIR(sir8),
    .Q(q8), .QN(qn8), .SOL(sol8), .SOR(sor8), .ZERO(zero8));

  univ_shift_reg #(.WIDTH(2), .RESET_VAL(2'b00)) dut2 (
    .CLK(CLK), .RST(rstr), .EN(en2), .MODE(mode2), .D(d2), .SIL(sil2), .SIR(sir2),
    .Q(q2), .QN(qn2), .SOL(sol2), .SOR(sor2), .ZERO(zero2));

  univ_shift_reg #(.WIDTH(32), .RESET_VAL(32'h0)) dut32 (
    .CLK(CLK), .RST(rstr), .EN(en32), .MODE(mode32), .D(d32), .SIL(sil32), .SIR(sir32),
    .Q(q32), .QN(qn32), .SOL(sol32), .SOR(sor32), .ZERO(zero32));

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  n_checks = 0;
  int  n_err    = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    sb_t s;
    s.tag = tag;
    s.exp = exp;
    sbq.push_back(s);
  endtask

  task automatic check(input logic [31:0] obs);
    sb_t s;
    n_checks++;
    if (sbq.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_underflow: observed %h with nothing expected", obs);
    end else begin
      s = sbq.pop_front();
      assert (obs === s.exp) else begin
        n_err++;
        $error("FAIL %s: observed %h expected %h", s.tag, obs, s.exp);
      end
    end
  endtask

  // Independent reference: whole-vector arithmetic on a w-bit value held in 32 bits.
  function automatic logic [31:0] model(input int w, input logic [31:0] q, input mode_t m,
                                        input logic [31:0] d, input logic sil,
                                        input logic sir, input logic en);
    logic [31:0] mask;
    logic [31:0] r;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    r = q;
    if (en) begin
      case (m)
        MODE_HOLD: r = q;
        MODE_SHL:  r = ((q << 1) | {31'd0, sil}) & mask;
        MODE_SHR:  r = (q >> 1) | ({31'd0, sir} << (w - 1));
        MODE_LOAD: r = d & mask;
        MODE_ROL:  r = ((q << 1) | {31'd0, q[w-1]}) & mask;
        MODE_ROR:  r = (q >> 1) | ({31'd0, q[0]} << (w - 1));
        MODE_CLR:  r = 32'd0;
        default:   r = mask;
      endcase
    end
    return r;
  endfunction

  // One directed clock on the 8-bit instance with a fixed expected Q.
  task automatic cyc8(input string tag, input mode_t m, input logic [7:0] d,
                      input logic en, input logic [7:0] exp);
    mode8 = m;
    d8    = d;
    en8   = en;
    push(tag, {24'd0, exp});
    @(posedge CLK);
    #1;
    check({24'd0, q8});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  rol_seq [8];
    logic [7:0]  shr_seq [8];
    logic [31:0] m2, m32, e2, e32;

    rol_seq = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0};
    shr_seq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};

    // 1: reset with the clock stopped takes effect immediately
    #2;
    rst8 = 1'b1;
    rstr = 1'b1;
    #1;
    push("rst_q", 32'hA5);     check({24'd0, q8});
    push("rst_qn", 32'h5A);    check({24'd0, qn8});
    push("rst_sol", 32'd1);    check({31'd0, sol8});
    push("rst_sor", 32'd1);    check({31'd0, sor8});
    push("rst_zero", 32'd0);   check({31'd0, zero8});
    push("rst_q2", 32'd0);     check({30'd0, q2});
    push("rst_q32", 32'd0);    check(q32);
    push("rst_zero32", 32'd1); check({31'd0, zero32});

    // the edge seen while reset is still high must not load D
    mode8 = MODE_LOAD;
    d8    = 8'h3C;
    en8   = 1'b1;
    clk_run = 1'b1;
    @(posedge CLK);
    #1;
    rst8 = 1'b0;
    rstr = 1'b0;
    push("rst_edge_ignored", 32'hA5); check({24'd0, q8});
    mode8 = MODE_HOLD;

    // 2: load then shift left with SIL=1
    sil8 = 1'b1;
    cyc8("load81", MODE_LOAD, 8'h81, 1'b1, 8'h81);
    push("sol_before_shl", 32'd1); check({31'd0, sol8});
    cyc8("shl1", MODE_SHL, 8'h00, 1'b1, 8'h03);
    push("sol_after_shl", 32'd0); check({31'd0, sol8});
    cyc8("shl2", MODE_SHL, 8'h00, 1'b1, 8'h07);
    cyc8("shl3", MODE_SHL, 8'h00, 1'b1, 8'h0F);
    sil8 = 1'b0;

    // 3: rotates
    cyc8("load81b", MODE_LOAD, 8'h81, 1'b1, 8'h81);
    cyc8("rol1", MODE_ROL, 8'h00, 1'b1, 8'h03);
    cyc8("ror1", MODE_ROR, 8'h00, 1'b1, 8'h81);
    cyc8("ror2", MODE_ROR, 8'h00, 1'b1, 8'hC0);
    for (int i = 0; i < 8; i++) begin
      cyc8($sformatf("rol8_%0d", i), MODE_ROL, 8'h00, 1'b1, rol_seq[i]);
    end

    // 4: enable low holds even in LOAD
    for (int i = 0; i < 5; i++) begin
      cyc8($sformatf("en0_hold_%0d", i), MODE_LOAD, 8'hFF, 1'b0, 8'hC0);
    end
    cyc8("en1_load", MODE_LOAD, 8'hFF, 1'b1, 8'hFF);
    push("qn_ff", 32'h00); check({24'd0, qn8});
    cyc8("clr", MODE_CLR, 8'hFF, 1'b1, 8'h00);
    push("zero_after_clr", 32'd1); check({31'd0, zero8});
    cyc8("set", MODE_SET, 8'h00, 1'b1, 8'hFF);
    cyc8("clr2", MODE_CLR, 8'h00, 1'b1, 8'h00);

    // 5: shift right with SIR=1, then reset in the middle of a shift train
    sir8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc8($sformatf("shr_%0d", i), MODE_SHR, 8'h00, 1'b1, shr_seq[i]);
    end
    push("sor_after_fill", 32'd1); check({31'd0, sor8});
    cyc8("clr3", MODE_CLR, 8'h00, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc8($sformatf("shr_b_%0d", i), MODE_SHR, 8'h00, 1'b1, shr_seq[i]);
    end
    rst8 = 1'b1;
    #1;
    push("midshift_rst_q", 32'hA5);  check({24'd0, q8});
    push("midshift_rst_qn", 32'h5A); check({24'd0, qn8});
    @(posedge CLK);
    #1;
    rst8 = 1'b0;
    push("midshift_rst_hold", 32'hA5); check({24'd0, q8});
    cyc8("after_rst_shr", MODE_SHR, 8'h00, 1'b1, 8'hD2);
    sir8 = 1'b0;

    // 6: random traffic on WIDTH=2 and WIDTH=32 against the reference model
    m2  = 32'd0;
    m32 = 32'd0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 31) == 0) begin
        rstr = 1'b1;
        #1;
        m2  = 32'd0;
        m32 = 32'd0;
        push("rnd_rst_q2", 32'd0);  check({30'd0, q2});
        push("rnd_rst_q32", 32'd0); check(q32);
        @(posedge CLK);
        #1;
        rstr = 1'b0;
        push("rnd_rst_edge_q32", 32'd0); check(q32);
      end
      en2    = ($urandom_range(0, 7) != 0);
      mode2  = mode_t'($urandom_range(0, 7));
      d2     = 2'($urandom_range(0, 3));
      sil2   = 1'($urandom_range(0, 1));
      sir2   = 1'($urandom_range(0, 1));
      en32   = ($urandom_range(0, 7) != 0);
      mode32 = mode_t'($urandom_range(0, 7));
      d32    = $urandom;
      sil32  = 1'($urandom_range(0, 1));
      sir32  = 1'($urandom_range(0, 1));
      e2  = model(2,  m2,  mode2,  {30'd0, d2}, sil2,  sir2,  en2);
      e32 = model(32, m32, mode32, d32,         sil32, sir32, en32);
      push("rnd_q2", e2);
      push("rnd_qn2", {30'd0, ~e2[1:0]});
      push("rnd_sol2", {31'd0, e2[1]});
      push("rnd_sor2", {31'd0, e2[0]});
      push("rnd_zero2", {31'd0, (e2[1:0] == 2'b00)});
      push("rnd_q32", e32);
      push("rnd_qn32", ~e32);
      push("rnd_sol32", {31'd0, e32[31]});
      push("rnd_sor32", {31'd0, e32[0]});
      push("rnd_zero32", {31'd0, (e32 == 32'd0)});
      @(posedge CLK);
      #1;
      check({30'd0, q2});
      check({30'd0, qn2});
      check({31'd0, sol2});
      check({31'd0, sor2});
      check({31'd0, zero2});
      check(q32);
      check(qn32);
      check({31'd0, sol32});
      check({31'd0, sor32});
      check({31'd0, zero32});
      m2  = e2;
      m32 = e32;
    end

    if (sbq.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
